seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 No parameters; operand and result width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 sign_flag  input  1  1 = signed (DIV), 0 = unsigned (DIVU); latched at accept.
REQ-006 A  input  32  dividend; latched at accept.
REQ-007 B  input  32  divisor; latched at accept.
REQ-008 busy  output  1  high while a divide is in progress.
REQ-009 done  output  1  one-cycle pulse; HI/LO valid.
REQ-010 HI  output  32  remainder.
REQ-011 LO  output  32  quotient.
REQ-012 div_zero  output  1  latched B==0 indicator for the last completed divide.

Function
REQ-013 States: IDLE, CALC, SIGN; a 5-bit iteration counter.
REQ-014 IDLE with start=1 at edge k: latch sign_flag, A, B; form |A|, |B| when sign_flag=1, else raw; go CALC, busy=1.
REQ-015 CALC: restoring shift-subtract, one quotient bit per edge, edges k+1..k+32; after the 32nd iteration go SIGN.
REQ-016 SIGN at edge k+33: write HI/LO; done=1 for exactly one cycle; busy=0; return IDLE. Total latency 33 cycles.
REQ-017 Signed: quotient truncates toward zero; quotient negated when A[31]!=B[31]; remainder takes sign of A.
REQ-018 Unsigned: no sign correction.
REQ-019 B==0: LO=32'hFFFFFFFF, HI=A (as latched), div_zero=1; same latency as normal. Otherwise div_zero=0 at completion.
REQ-020 Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, div_zero=0.
REQ-021 start while busy: ignored, no effect on operands or state.
REQ-022 start high during the done cycle: accepted (state is IDLE), new divide begins at that edge.
REQ-023 HI, LO, div_zero hold their last completed values until the next SIGN write; they do not change during CALC.
REQ-024 Operand inputs may change freely after accept without affecting the result.

Reset
REQ-025 rst=1 at any edge: state IDLE, counter 0, busy=0, done=0, HI=0, LO=0, div_zero=0.
REQ-026 rst during CALC or SIGN aborts the divide; no done pulse is produced; start is ignored while rst=1.

Configuration
REQ-027 Macro DIV_ZERO_FAST_EN defined: accept with B==0 goes directly IDLE->SIGN, skipping CALC; results per REQ-019 written at edge k+1, done at k+1 (latency 1).
REQ-028 DIV_ZERO_FAST_EN undefined: B==0 follows the normal 33-cycle path; all other behaviour identical either way.

Verification
REQ-029 Unsigned A=100, B=7, sign_flag=0 -> 33 cycles after accept: done=1, LO=14, HI=2, div_zero=0.
REQ-030 Signed A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; unsigned same operands -> LO=0x7FFFFFFC, HI=1.
REQ-031 Signed A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, done exactly at edge k+33.
REQ-032 A=5, B=0 -> LO=0xFFFFFFFF, HI=5, div_zero=1; done at k+33, or at k+1 with DIV_ZERO_FAST_EN.
REQ-033 Accept A=100, B=7; pulse start with A=9, B=3 at k+5; assert rst at k+10 -> busy=0 at k+11, no done, HI=LO=0; then A=9, B=3 -> LO=3, HI=0.
REQ-034 Back-to-back: start held high continuously -> done pulses every 34 cycles, each with correct results.

Source files
------------

// File: rtl/seq_div.sv
// seq_div: 32-bit sequential restoring divider (signed DIV / unsigned DIVU).
//
// An accepted request spends 32 cycles in CALC, producing one quotient bit
// per cycle on operand magnitudes. One SIGN cycle then applies the sign
// correction, writes HI (remainder) and LO (quotient), and pulses done.
// A zero divisor yields LO=all-ones and HI=latched dividend, with div_zero set.
//
// Optional build macro:
//   DIV_ZERO_FAST_EN - a zero divisor skips CALC; results and done appear
//                      one cycle after accept instead of 33.
module seq_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign_flag,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;      // dividend magnitude shifting out, quotient shifting in
    logic [31:0] rem_q, rem_d;      // partial remainder
    logic [31:0] dvs_q, dvs_d;      // divisor magnitude
    logic [31:0] a_q, a_d;          // raw dividend, needed for the zero-divisor HI value
    logic        a_neg_q, a_neg_d;  // signed mode and dividend negative
    logic        b_neg_q, b_neg_d;  // signed mode and divisor negative
    logic        zero_q, zero_d;    // latched divisor was zero
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;
    logic        done_q, done_d;

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    // The true difference is always below 2^32 because the remainder stays below the divisor.
    logic [32:0] rem_shift;
    logic [31:0] rem_diff;
    logic        fits;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Datapath helpers for the iteration step and the final sign correction.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        rem_diff  = rem_shift[31:0] - dvs_q;
        fits      = (rem_shift >= {1'b0, dvs_q});
        // Quotient negative iff operand signs differ; remainder follows the dividend.
        // The 0x80000000 / -1 case falls out naturally: magnitudes give 0x80000000, no negation.
        quo_fix   = (a_neg_q ^ b_neg_q) ? (32'd0 - quo_q) : quo_q;
        rem_fix   = a_neg_q ? (32'd0 - rem_q) : rem_q;
    end

    // Next-state and register-update logic; every register holds unless its state acts on it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        zero_d  = zero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    a_neg_d = sign_flag & A[31];
                    b_neg_d = sign_flag & B[31];
                    quo_d   = (sign_flag & A[31]) ? (32'd0 - A) : A;
                    dvs_d   = (sign_flag & B[31]) ? (32'd0 - B) : B;
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    zero_d  = (B == 32'd0);
`ifdef DIV_ZERO_FAST_EN
                    state_d = (B == 32'd0) ? SIGN : CALC;
`else
                    state_d = CALC;
`endif
                end
            end

            CALC: begin
                quo_d = {quo_q[30:0], fits};
                rem_d = fits ? rem_diff : rem_shift[31:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = SIGN;
                end
            end

            SIGN: begin
                if (zero_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = a_q;
                    dz_d = 1'b1;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                    dz_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that aborts any divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            a_q     <= 32'd0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    // Output mapping; busy covers both CALC and SIGN.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = done_q;
        HI       = hi_q;
        LO       = lo_q;
        div_zero = dz_q;
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: table vectors, randomized operands against
// an arithmetic reference model, and hand-written reset/back-to-back sequences.
// Honours DIV_ZERO_FAST_EN for the zero-divisor latency.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign_flag;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_lo = 32'd0;
    logic [31:0] last_hi = 32'd0;
    logic        last_dz = 1'b0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    seq_div dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign_flag (sign_flag),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .HI        (HI),
        .LO        (LO),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division with the documented special cases.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi,
                                    output logic dz);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
            dz = 1'b1;
        end else begin
            dz = 1'b0;
            if (s) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end else begin
                lo = a / b;
                hi = a % b;
            end
        end
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
        int lat;
        lat = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) lat = 1;
`endif
        return lat;
    endfunction

    // One divide: accept, poke start mid-flight (must be ignored), scramble operands,
    // wait for done with a bound, then check latency, results, holds and pulse width.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] elo,
                           input logic [31:0] ehi, input logic edz);
        int   lat;
        logic held_ok;
        logic busy_ok;
        sign_flag = s;
        A         = a;
        B         = b;
        start     = 1'b1;
        tick();                        // accept edge k
        start     = 1'b0;
        A         = $urandom;
        B         = $urandom;
        sign_flag = 1'($urandom);
        lat       = 0;
        held_ok   = 1'b1;
        busy_ok   = 1'b1;
        while (lat < 40) begin
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (HI !== last_hi || LO !== last_lo || div_zero !== last_dz) held_ok = 1'b0;
            if (lat == 4) begin
                start = 1'b1;
                A     = 32'd9;
                B     = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        $display("div %s s=%0b a=%h b=%h -> lo=%h hi=%h dz=%b lat=%0d",
                 tag, s, a, b, LO, HI, div_zero, lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_latency(b)));
        chk({tag, " LO"}, LO, elo);
        chk({tag, " HI"}, HI, ehi);
        chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        chk({tag, " busy during calc"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " outputs held"}, {31'd0, held_ok}, 32'd1);
        last_lo = elo;
        last_hi = ehi;
        last_dz = edz;
        tick();
        chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] elo;
        logic [31:0] ehi;
        logic        edz;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic        no_done;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
        vecs[11] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        sign_flag = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        repeat (3) tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                    vecs[i].lo, vecs[i].hi, vecs[i].dz);
        end

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'd0 - 32'($urandom_range(1, 20));
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            ref_div(s, a, b, elo, ehi, edz);
            run_div($sformatf("rnd%0d", i), s, a, b, elo, ehi, edz);
        end

        // Reset mid-divide aborts it; start during reset is ignored.
        sign_flag = 1'b0;
        A         = 32'd100;
        B         = 32'd7;
        start     = 1'b1;
        tick();                        // accept edge k
        start = 1'b0;
        repeat (4) tick();
        A     = 32'd9;
        B     = 32'd3;
        start = 1'b1;                  // sampled at k+5 while busy
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst   = 1'b1;                  // sampled at k+10
        start = 1'b1;
        tick();
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("abort busy k+11", {31'd0, busy}, 32'd0);
        no_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) no_done = 1'b0;
            tick();
        end
        chk("abort no done", {31'd0, no_done}, 32'd1);
        $display("abort sequence: busy=%b HI=%h LO=%h", busy, HI, LO);
        last_lo = 32'd0;
        last_hi = 32'd0;
        last_dz = 1'b0;
        run_div("after_abort", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Back-to-back with start held high: done every 34 cycles.
        s         = 1'b0;
        a         = 32'd100;
        b         = 32'd7;
        sign_flag = s;
        A         = a;
        B         = b;
        start     = 1'b1;
        ref_div(s, a, b, elo, ehi, edz);
        tick();                        // first accept
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        for (int p = 0; p < 4; p++) begin
            $display("b2b pulse %0d lat=%0d lo=%h hi=%h", p, lat, LO, HI);
            chk($sformatf("b2b%0d period", p), 32'(lat), (p == 0) ? 32'd33 : 32'd34);
            chk($sformatf("b2b%0d LO", p), LO, elo);
            chk($sformatf("b2b%0d HI", p), HI, ehi);
            chk($sformatf("b2b%0d div_zero", p), {31'd0, div_zero}, {31'd0, edz});
            s = 1'($urandom);
            a = $urandom;
            b = $urandom_range(1, 1000);
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            sign_flag = s;
            A         = a;
            B         = b;
            ref_div(s, a, b, elo, ehi, edz);
            lat = 0;
            while (lat < 40) begin
                tick();
                lat++;
                if (done) break;
            end
        end
        start = 1'b0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
